// File: rtl/fft16_ctrl.sv
// Stage/butterfly sequencer for a 16-point radix-2 DIT in-place FFT.
// Issues operand addresses and twiddle selects, then replays the addresses for write-back.
module fft16_ctrl #(
  parameter int BF_LATENCY = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_bf_valid,
  output logic [3:0] o_addr_a,
  output logic [3:0] o_addr_b,
  output logic [2:0] o_tw_sel,
  output logic [1:0] o_stage,
  output logic       o_wr_en,
  output logic [3:0] o_wr_addr_a,
  output logic [3:0] o_wr_addr_b
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(BF_LATENCY - 1);

  // Valid/ready contract: i_start is a request taken only in IDLE (no ready
  // signal, requests at other times are dropped); o_bf_valid and o_wr_en are
  // strobes with no backpressure, consumers must accept them on that cycle.

  state_t     state, state_nx;
  logic [1:0] s, s_nx;
  logic [2:0] k, k_nx;
  logic [2:0] d, d_nx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      s     <= '0;
      k     <= '0;
      d     <= '0;
    end else begin
      state <= state_nx;
      s     <= s_nx;
      k     <= k_nx;
      d     <= d_nx;
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s;
    k_nx     = k;
    d_nx     = d;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nx = ISSUE;
          s_nx     = '0;
          k_nx     = '0;
        end
      end
      ISSUE: begin
        k_nx = k + 3'd1;
        if (k == 3'd7) begin
          state_nx = DRAIN;
          d_nx     = DRAIN_INIT;
        end
      end
      DRAIN: begin
        if (d == 3'd0) begin
          if (s == 2'd3) begin
            state_nx = DONE;
          end else begin
            state_nx = ISSUE;
            s_nx     = s + 2'd1;
            k_nx     = '0;
          end
        end else begin
          d_nx = d - 3'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign o_bf_valid = (state == ISSUE);
  assign o_busy     = (state == ISSUE) || (state == DRAIN);
  assign o_done     = (state == DONE);
  assign o_stage    = s;

  // Butterfly k of stage s: span = 2^s, group = k >> s, position = k mod span.
  logic [3:0] span, pos, grp, a_calc, b_calc, tw_full;

  always_comb begin
    span    = 4'd1 << s;
    pos     = {1'b0, k} & (span - 4'd1);
    grp     = {1'b0, k} >> s;
    a_calc  = (grp << ({1'b0, s} + 3'd1)) + pos;
    b_calc  = a_calc + span;
    tw_full = pos << (3'd3 - {1'b0, s});
  end

  // Last issued addresses are held so the RAM ports stay quiet between stages.
  logic [3:0] addr_a_q, addr_b_q;
  logic [2:0] tw_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else if (o_bf_valid) begin
      addr_a_q <= a_calc;
      addr_b_q <= b_calc;
      tw_q     <= tw_full[2:0];
    end
  end

  assign o_addr_a = o_bf_valid ? a_calc       : addr_a_q;
  assign o_addr_b = o_bf_valid ? b_calc       : addr_b_q;
  assign o_tw_sel = o_bf_valid ? tw_full[2:0] : tw_q;

  // Write-back delay line: {valid, addr_a, addr_b} per entry.
  logic [8:0] dl [BF_LATENCY];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BF_LATENCY; i++) dl[i] <= '0;
    end else begin
      dl[0] <= {o_bf_valid, o_addr_a, o_addr_b};
      for (int i = 1; i < BF_LATENCY; i++) dl[i] <= dl[i-1];
    end
  end

  assign o_wr_en     = dl[BF_LATENCY-1][8];
  assign o_wr_addr_a = dl[BF_LATENCY-1][7:4];
  assign o_wr_addr_b = dl[BF_LATENCY-1][3:0];

endmodule
